// File: rtl/hwag_pkg.sv
// Shared types and defaults for the HWAG synchronisation supervisor.
package hwag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_SYNC   = 2'd3
  } hwag_sync_state_t;

  localparam int HWAG_TCNT_WIDTH = 6;
  localparam int HWAG_TOOTH_TOP  = 57;
  localparam int HWAG_CONFIRM_W  = 3;

endpackage

// File: rtl/hwag_sync_ctrl_if.sv
// Datapath <-> sync supervisor signal bundle; master is the datapath/register side.
interface hwag_sync_ctrl_if #(
  parameter int TCNT_WIDTH   = hwag_pkg::HWAG_TCNT_WIDTH,
  parameter int ERRCNT_WIDTH = 8
);
  import hwag_pkg::*;

  logic                    en;
  logic                    tooth_edge;
  logic                    gap_found;
  logic                    pcnt_ovf;
  logic                    err_clr;
  hwag_sync_state_t        state;
  logic                    sync;
  logic [TCNT_WIDTH-1:0]   tooth;
  logic                    rev;
  logic                    sync_err;
  logic                    stall;
  logic [ERRCNT_WIDTH-1:0] err_cnt;

  modport master (
    output en, tooth_edge, gap_found, pcnt_ovf, err_clr,
    input  state, sync, tooth, rev, sync_err, stall, err_cnt
  );

  modport slave (
    input  en, tooth_edge, gap_found, pcnt_ovf, err_clr,
    output state, sync, tooth, rev, sync_err, stall, err_cnt
  );

endinterface

// File: rtl/hwag_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module hwag_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {WIDTH{1'b1}}))
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hwag_sync_ctrl.sv
// Wheel sync supervisor: acquires, confirms and tracks 60-2 crank position.
//   state  | meaning
//   IDLE   | disabled, tooth/confirm held at 0
//   SEARCH | waiting for any gap
//   VERIFY | counting correctly placed gaps up to CONFIRM_GAPS
//   SYNC   | position trusted, rev per gap
module hwag_sync_ctrl
  import hwag_pkg::*;
#(
  parameter int TCNT_WIDTH   = HWAG_TCNT_WIDTH,
  parameter int TOOTH_TOP    = HWAG_TOOTH_TOP,
  parameter int CONFIRM_GAPS = 2,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  hwag_sync_ctrl_if.slave  bus
);

  hwag_sync_state_t          state_q, state_d;
  logic [TCNT_WIDTH-1:0]     tooth_q, tooth_d;
  logic [HWAG_CONFIRM_W-1:0] confirm_q, confirm_d, confirm_inc;
  logic                      edge_dly_q;
  logic                      rev_q, rev_d;
  logic                      sync_err_q, sync_err_d;
  logic                      stall_q, stall_d;
  logic                      sync_q, sync_d;
  logic [ERRCNT_WIDTH-1:0]   err_cnt;

  logic active, exp_gap, good, ovf, evt, err_inc;

  assign active      = bus.en && (state_q != ST_IDLE);
  assign exp_gap     = (tooth_q == TCNT_WIDTH'(TOOTH_TOP));
  assign good        = (bus.gap_found == exp_gap);
  assign ovf         = active && bus.pcnt_ovf;
  // a stall discards any tooth edge being evaluated in the same cycle
  assign evt         = active && !bus.pcnt_ovf && edge_dly_q;
  assign err_inc     = evt && (state_q inside {ST_VERIFY, ST_SYNC}) && !good;
  assign confirm_inc = confirm_q + HWAG_CONFIRM_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tooth_q    <= '0;
      confirm_q  <= '0;
      edge_dly_q <= 1'b0;
      rev_q      <= 1'b0;
      sync_err_q <= 1'b0;
      stall_q    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tooth_q    <= tooth_d;
      confirm_q  <= confirm_d;
      edge_dly_q <= bus.tooth_edge;
      rev_q      <= rev_d;
      sync_err_q <= sync_err_d;
      stall_q    <= stall_d;
      sync_q     <= sync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tooth_d   = tooth_q;
    confirm_d = confirm_q;
    if (!bus.en || (state_q == ST_IDLE)) begin
      state_d   = bus.en ? ST_SEARCH : ST_IDLE;
      tooth_d   = '0;
      confirm_d = '0;
    end else if (ovf) begin
      state_d   = ST_SEARCH;
      tooth_d   = '0;
      confirm_d = '0;
    end else if (evt) begin
      case (state_q)
        ST_SEARCH: begin
          if (bus.gap_found) begin
            tooth_d   = '0;
            confirm_d = HWAG_CONFIRM_W'(1);
            state_d   = (CONFIRM_GAPS == 1) ? ST_SYNC : ST_VERIFY;
          end
        end
        ST_VERIFY, ST_SYNC: begin
          if (!good) begin
            state_d   = ST_SEARCH;
            tooth_d   = '0;
            confirm_d = '0;
          end else if (exp_gap) begin
            tooth_d = '0;
            if (state_q == ST_VERIFY) begin
              confirm_d = confirm_inc;
              if (confirm_inc == HWAG_CONFIRM_W'(CONFIRM_GAPS))
                state_d = ST_SYNC;
            end
          end else begin
            tooth_d = tooth_q + TCNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rev_d      = evt && (state_q == ST_SYNC) && good && exp_gap;
    sync_err_d = err_inc;
    stall_d    = ovf;
    sync_d     = (state_d == ST_SYNC);
  end

  hwag_sat_cnt #(.WIDTH(ERRCNT_WIDTH)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (bus.err_clr),
    .cnt (err_cnt)
  );

  assign bus.state    = state_q;
  assign bus.sync     = sync_q;
  assign bus.tooth    = tooth_q;
  assign bus.rev      = rev_q;
  assign bus.sync_err = sync_err_q;
  assign bus.stall    = stall_q;
  assign bus.err_cnt  = err_cnt;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Scoreboard bench for hwag_sync_ctrl (CONFIRM_GAPS=2, ERRCNT_WIDTH=2).
module tb_hwag_sync_ctrl;

  typedef struct {
    int         due;
    logic [1:0] st;
    logic [5:0] tooth;
    logic       ct;
    logic       rev;
    logic       serr;
    logic       stall;
    logic [1:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rev_cnt = 0;
  int   exp_ec = 0;
  exp_t sb[$];

  hwag_sync_ctrl_if #(.TCNT_WIDTH(6), .ERRCNT_WIDTH(2)) bus ();

  hwag_sync_ctrl #(
    .TCNT_WIDTH(6), .TOOTH_TOP(57), .CONFIRM_GAPS(2), .ERRCNT_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("sb_late", sb[0].due, cyc);
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("state", 32'(bus.state), 32'(e.st));
      chk("sync", 32'(bus.sync), 32'(e.st == 2'd3));
      if (e.ct) chk("tooth", 32'(bus.tooth), 32'(e.tooth));
      chk("rev", 32'(bus.rev), 32'(e.rev));
      chk("sync_err", 32'(bus.sync_err), 32'(e.serr));
      chk("stall", 32'(bus.stall), 32'(e.stall));
      chk("err_cnt", 32'(bus.err_cnt), 32'(e.ec));
    end
    if (bus.rev) rev_cnt++;
  end

  task automatic push(input int due, input int st, input int tooth, input bit ct,
                      input bit rev, input bit serr, input bit stall);
    exp_t e;
    e.due = due; e.st = 2'(st); e.tooth = 6'(tooth); e.ct = ct;
    e.rev = rev; e.serr = serr; e.stall = stall; e.ec = 2'(exp_ec);
    sb.push_back(e);
  endtask

  // One tooth event: edge pulse, gap_found held through the evaluation cycle.
  task automatic tooth_ev(input bit gap, input int et, input int es, input bit erev,
                          input bit eserr, input bit ct, input bit clr = 1'b0);
    @(posedge clk); #1;
    push(cyc + 2, es, et, ct, erev, eserr, 1'b0);
    bus.tooth_edge = 1'b1;
    bus.gap_found  = gap;
    @(posedge clk); #1;
    bus.tooth_edge = 1'b0;
    bus.err_clr    = clr;
    @(posedge clk); #1;
    bus.gap_found  = 1'b0;
    bus.err_clr    = 1'b0;
  endtask

  task automatic acquire();
    tooth_ev(1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 57; i++) tooth_ev(1'b0, i, 2, 1'b0, 1'b0, 1'b1);
    tooth_ev(1'b1, 0, 3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_teeth(input int last);
    for (int i = 1; i <= last; i++) tooth_ev(1'b0, i, 3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.en = 1'b0; bus.tooth_edge = 1'b0; bus.gap_found = 1'b0;
    bus.pcnt_ovf = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.en = 1'b1;
    push(cyc + 1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // acquisition: gapless edges are ignored in SEARCH
    for (int i = 0; i < 10; i++) tooth_ev(1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    acquire();
    run_teeth(57);
    tooth_ev(1'b1, 0, 3, 1'b1, 1'b0, 1'b1);
    drain();

    // steady state: three revolutions
    rev_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      run_teeth(57);
      tooth_ev(1'b1, 0, 3, 1'b1, 1'b0, 1'b1);
    end
    drain();
    chk("rev_count", rev_cnt, 3);

    // gap at tooth 30, then missing gap at tooth 57
    run_teeth(30);
    exp_ec = 1;
    tooth_ev(1'b1, 0, 1, 1'b0, 1'b1, 1'b0);
    acquire();
    run_teeth(57);
    exp_ec = 2;
    tooth_ev(1'b0, 0, 1, 1'b0, 1'b1, 1'b0);

    // stall coinciding with edge_d
    acquire();
    run_teeth(5);
    @(posedge clk); #1;
    push(cyc + 2, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(cyc + 3, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.tooth_edge = 1'b1;
    bus.gap_found  = 1'b0;
    @(posedge clk); #1;
    bus.tooth_edge = 1'b0;
    bus.pcnt_ovf   = 1'b1;
    @(posedge clk); #1;
    bus.pcnt_ovf   = 1'b0;
    drain();

    // clear, saturate, then clear racing an increment
    bus.err_clr = 1'b1;
    exp_ec = 0;
    push(cyc + 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tooth_ev(1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
      exp_ec = (exp_ec == 3) ? 3 : exp_ec + 1;
      tooth_ev(1'b1, 0, 1, 1'b0, 1'b1, 1'b0);
    end
    tooth_ev(1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
    exp_ec = 0;
    tooth_ev(1'b1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b1);

    // en drops while a misplaced gap is being evaluated: IDLE, no pulses
    acquire();
    run_teeth(3);
    @(posedge clk); #1;
    push(cyc + 1, 3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    push(cyc + 2, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(cyc + 3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.tooth_edge = 1'b1;
    bus.gap_found  = 1'b1;
    @(posedge clk); #1;
    bus.tooth_edge = 1'b0;
    bus.en         = 1'b0;
    @(posedge clk); #1;
    bus.gap_found  = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
